// File: rtl/spi_mem_controller_if.sv
// CPU-side request/response bus for spi_mem_controller: one byte read or write per request.
interface spi_mem_controller_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [7:0]            req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [7:0]            rsp_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_mem_controller.sv
// Serialises single-byte CPU memory requests onto a 23LC-style SPI SRAM
// (cmd, 16-bit address, data byte; SPI mode 0).
module spi_mem_controller #(
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_mem_controller_if.slave  bus,
    output logic                 spi_cs_n,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int unsigned      DIV_W     = 4;
    localparam int unsigned      BIT_W     = 6;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(31);
    localparam logic [BIT_W-1:0] BIT_DATA  = BIT_W'(24);
    localparam logic [7:0]       CMD_READ  = 8'h03;
    localparam logic [7:0]       CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state,     w_state_nxt;
    logic [31:0]      r_shift,     w_shift_nxt;
    logic [7:0]       r_cap,       w_cap_nxt;
    logic [BIT_W-1:0] r_bit,       w_bit_nxt;
    logic [DIV_W-1:0] r_div,       w_div_nxt;
    logic             r_high,      w_high_nxt;
    logic             r_write,     w_write_nxt;
    logic             r_cs_n,      w_cs_n_nxt;
    logic             r_sck,       w_sck_nxt;
    logic             r_mosi,      w_mosi_nxt;
    logic             r_ready,     w_ready_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]       r_rdata,     w_rdata_nxt;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [15:0]           w_addr16;

    assign w_addr   = bus.req_addr;
    assign w_addr16 = 16'(w_addr);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cap       <= '0;
            r_bit       <= '0;
            r_div       <= '0;
            r_high      <= 1'b0;
            r_write     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cap       <= w_cap_nxt;
            r_bit       <= w_bit_nxt;
            r_div       <= w_div_nxt;
            r_high      <= w_high_nxt;
            r_write     <= w_write_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_sck       <= w_sck_nxt;
            r_mosi      <= w_mosi_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cap_nxt       = r_cap;
        w_bit_nxt       = r_bit;
        w_div_nxt       = r_div;
        w_high_nxt      = r_high;
        w_write_nxt     = r_write;
        w_cs_n_nxt      = r_cs_n;
        w_sck_nxt       = r_sck;
        w_mosi_nxt      = r_mosi;
        w_ready_nxt     = r_ready;
        w_busy_nxt      = r_busy;
        w_rsp_valid_nxt = 1'b0;
        w_rdata_nxt     = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_ready) begin
                    w_state_nxt = S_SHIFT;
                    w_shift_nxt = {bus.req_write ? CMD_WRITE : CMD_READ, w_addr16,
                                   bus.req_write ? bus.req_wdata : 8'h00};
                    w_write_nxt = bus.req_write;
                    w_cs_n_nxt  = 1'b0;
                    w_sck_nxt   = 1'b0;
                    w_mosi_nxt  = w_shift_nxt[31];
                    w_bit_nxt   = '0;
                    w_div_nxt   = '0;
                    w_high_nxt  = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_SHIFT: begin
                // MISO is taken one clk after SCK rises; only the data byte is kept
                if (r_high && (r_div == '0) && (r_bit >= BIT_DATA)) begin
                    w_cap_nxt = {r_cap[6:0], spi_miso};
                end
                if (r_div != DIV_LAST) begin
                    w_div_nxt = r_div + DIV_W'(1);
                end else begin
                    w_div_nxt = '0;
                    if (!r_high) begin
                        w_high_nxt = 1'b1;
                        w_sck_nxt  = 1'b1;
                    end else begin
                        w_high_nxt = 1'b0;
                        w_sck_nxt  = 1'b0;
                        if (r_bit == BIT_LAST) begin
                            w_state_nxt     = S_DONE;
                            w_cs_n_nxt      = 1'b1;
                            w_mosi_nxt      = 1'b0;
                            w_rsp_valid_nxt = 1'b1;
                            if (!r_write) begin
                                w_rdata_nxt = w_cap_nxt;
                            end
                        end else begin
                            w_bit_nxt   = r_bit + BIT_W'(1);
                            w_shift_nxt = {r_shift[30:0], 1'b0};
                            w_mosi_nxt  = r_shift[30];
                        end
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.busy      = r_busy;
    assign spi_cs_n      = r_cs_n;
    assign spi_sck       = r_sck;
    assign spi_mosi      = r_mosi;
endmodule

// File: tb/tb_spi_mem_controller.sv
// Directed bench for spi_mem_controller: two instances (CLK_DIV=1/16-bit, CLK_DIV=3/8-bit)
// with a cycle-sampled SPI SRAM model that records MOSI and returns a programmed byte.
module tb_spi_mem_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_mem_controller_if #(.ADDR_WIDTH(16)) bus_a ();
    spi_mem_controller_if #(.ADDR_WIDTH(8))  bus_b ();

    logic [1:0]  valid;
    logic [1:0]  wr;
    logic [15:0] addr  [2];
    logic [7:0]  wdata [2];

    wire  [1:0]  cs_n, sck, mosi, miso, ready, rspv, busy;
    wire  [7:0]  rdata0, rdata1;

    assign bus_a.req_valid = valid[0];
    assign bus_a.req_write = wr[0];
    assign bus_a.req_addr  = addr[0];
    assign bus_a.req_wdata = wdata[0];
    assign bus_b.req_valid = valid[1];
    assign bus_b.req_write = wr[1];
    assign bus_b.req_addr  = addr[1][7:0];
    assign bus_b.req_wdata = wdata[1];
    assign ready  = {bus_b.req_ready, bus_a.req_ready};
    assign rspv   = {bus_b.rsp_valid, bus_a.rsp_valid};
    assign busy   = {bus_b.busy,      bus_a.busy};
    assign rdata0 = bus_a.rsp_rdata;
    assign rdata1 = bus_b.rsp_rdata;

    spi_mem_controller #(.CLK_DIV(1), .ADDR_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_mem_controller #(.CLK_DIV(3), .ADDR_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    // SPI SRAM model: bit_cnt counts completed bits (SCK falls) of the current frame
    int          bit_cnt   [2] = '{0, 0};
    int          rises     [2] = '{0, 0};
    int          rsp_cnt   [2] = '{0, 0};
    logic [31:0] frame     [2] = '{32'h0, 32'h0};
    logic [7:0]  miso_byte [2] = '{8'h00, 8'h00};
    logic [1:0]  prev_cs  = 2'b11;
    logic [1:0]  prev_sck = 2'b00;

    function automatic logic miso_bit(input int cnt, input logic [7:0] b);
        int idx;
        if (cnt < 24 || cnt > 31) return 1'b0;
        idx = 31 - cnt;
        return b[idx[2:0]];
    endfunction

    assign miso[0] = miso_bit(bit_cnt[0], miso_byte[0]);
    assign miso[1] = miso_bit(bit_cnt[1], miso_byte[1]);

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rspv[g]) rsp_cnt[g]++;
            if (!cs_n[g] && prev_cs[g]) begin
                bit_cnt[g] = 0;
                frame[g]   = '0;
                rises[g]   = 0;
            end
            if (!cs_n[g] && sck[g] && !prev_sck[g]) begin
                frame[g] = {frame[g][30:0], mosi[g]};
                rises[g]++;
            end
            if (!sck[g] && prev_sck[g]) bit_cnt[g]++;
            prev_cs[g]  = cs_n[g];
            prev_sck[g] = sck[g];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int g, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic v);
        wr[g]    = w;
        addr[g]  = a;
        wdata[g] = d;
        valid[g] = v;
    endtask

    // Accept edge, then every SHIFT cycle against the ideal waveform, then the DONE cycle
    task automatic run_frame(input int g, input int div, input logic [31:0] f,
                             input bit hold, input int poke_at);
        int   bad;
        int   k;
        logic exp_sck;
        logic exp_mosi;
        bad = 0;
        @(posedge clk); #1;
        if (!hold) valid[g] = 1'b0;
        for (int i = 1; i <= 64 * div; i++) begin
            k        = (i - 1) / (2 * div);
            exp_sck  = (((i - 1) / div) % 2) == 1;
            exp_mosi = f[5'(31 - k)];
            if (cs_n[g] !== 1'b0 || sck[g] !== exp_sck || mosi[g] !== exp_mosi ||
                rspv[g] !== 1'b0 || busy[g] !== 1'b1 || ready[g] !== 1'b0) bad++;
            if (i == poke_at) begin
                valid[g] = 1'b1;
                wr[g]    = ~wr[g];
                addr[g]  = ~addr[g];
                wdata[g] = ~wdata[g];
            end
            if (i == poke_at + 1) valid[g] = 1'b0;
            @(posedge clk); #1;
        end
        check($sformatf("shift_waveform_%0d", g), 32'(bad), 32'd0);
        check($sformatf("done_rsp_valid_%0d", g), 32'(rspv[g]), 32'd1);
        check($sformatf("done_cs_n_%0d", g), 32'(cs_n[g]), 32'd1);
        check($sformatf("done_sck_mosi_%0d", g), 32'({sck[g], mosi[g]}), 32'd0);
        check($sformatf("done_ready_%0d", g), 32'(ready[g]), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        valid    = 2'b00;
        wr       = 2'b00;
        addr[0]  = '0;
        addr[1]  = '0;
        wdata[0] = '0;
        wdata[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n_held", 32'(cs_n), 32'h3);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ready", 32'(ready), 32'h3);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_rsp_valid", 32'(rspv), 32'h0);
        check("reset_rdata", 32'({rdata1, rdata0}), 32'h0);
        check("reset_sck_mosi", 32'({sck, mosi}), 32'h0);

        // Read 0x1234, SRAM returns 0xA5
        miso_byte[0] = 8'hA5;
        drive(0, 1'b0, 16'h1234, 8'h00, 1'b1);
        run_frame(0, 1, 32'h0312_3400, 1'b0, -1);
        check("read_rdata", 32'(rdata0), 32'hA5);
        check("read_frame", frame[0], 32'h0312_3400);
        check("read_sck_rises", 32'(rises[0]), 32'd32);
        @(posedge clk); #1;
        check("read_ready_after", 32'({ready[0], rspv[0], busy[0]}), 32'h4);
        check("read_rsp_count", 32'(rsp_cnt[0]), 32'd1);

        // Write 0x00FF <- 0x5A, inputs disturbed and req_valid pulsed mid-frame
        miso_byte[0] = 8'hFF;
        drive(0, 1'b1, 16'h00FF, 8'h5A, 1'b1);
        run_frame(0, 1, 32'h0200_FF5A, 1'b0, 20);
        check("write_rdata_kept", 32'(rdata0), 32'hA5);
        check("write_frame", frame[0], 32'h0200_FF5A);
        repeat (3) @(posedge clk);
        #1;
        check("write_no_extra_txn", 32'(rsp_cnt[0]), 32'd2);
        check("write_idle_after", 32'({busy[0], cs_n[0]}), 32'h1);

        // Two reads back-to-back with req_valid held
        miso_byte[0] = 8'h11;
        drive(0, 1'b0, 16'h0010, 8'h00, 1'b1);
        run_frame(0, 1, 32'h0300_1000, 1'b1, -1);
        check("b2b_first_rdata", 32'(rdata0), 32'h11);
        addr[0]      = 16'h0020;
        miso_byte[0] = 8'h22;
        @(posedge clk); #1;
        check("b2b_gap_cs_n", 32'(cs_n[0]), 32'd1);
        check("b2b_gap_ready", 32'(ready[0]), 32'd1);
        run_frame(0, 1, 32'h0300_2000, 1'b0, -1);
        check("b2b_second_rdata", 32'(rdata0), 32'h22);
        check("b2b_second_frame", frame[0], 32'h0300_2000);
        @(posedge clk); #1;
        check("b2b_rsp_count", 32'(rsp_cnt[0]), 32'd4);

        // CLK_DIV=3, 8-bit address 0x80
        miso_byte[1] = 8'h3C;
        drive(1, 1'b0, 16'h0080, 8'h00, 1'b1);
        run_frame(1, 3, 32'h0300_8000, 1'b0, -1);
        check("div3_rdata", 32'(rdata1), 32'h3C);
        check("div3_frame", frame[1], 32'h0300_8000);
        check("div3_sck_rises", 32'(rises[1]), 32'd32);
        @(posedge clk); #1;
        check("div3_ready_after", 32'(ready[1]), 32'd1);
        check("div3_rsp_count", 32'(rsp_cnt[1]), 32'd1);

        // Reset during the address phase
        miso_byte[0] = 8'hC3;
        drive(0, 1'b0, 16'h4321, 8'h00, 1'b1);
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_pre_cs_n", 32'(cs_n[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_cs_n", 32'(cs_n[0]), 32'd1);
        check("abort_sck_mosi", 32'({sck[0], mosi[0]}), 32'h0);
        check("abort_rdata", 32'(rdata0), 32'h00);
        check("abort_ready_busy", 32'({ready[0], busy[0], rspv[0]}), 32'h4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_rsp", 32'(rsp_cnt[0]), 32'd4);

        // Fresh read after reset
        miso_byte[0] = 8'h96;
        drive(0, 1'b0, 16'h0042, 8'h00, 1'b1);
        run_frame(0, 1, 32'h0300_4200, 1'b0, -1);
        check("post_reset_rdata", 32'(rdata0), 32'h96);
        check("post_reset_frame", frame[0], 32'h0300_4200);
        @(posedge clk); #1;
        check("post_reset_rsp_count", 32'(rsp_cnt[0]), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
